// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug/trace path: register-file geometry,
// dump FSM state encoding and the {idx, data} trace record.
package cpu_dbg_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Record layout is also consumed by the UART/display formatter.
  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } dump_rec_t;

endpackage

// File: rtl/rf_dump_if.sv
// Register-file debug read port plus the outgoing record stream.
// master = dump engine, slave = register file / trace sink side.
interface rf_dump_if import cpu_dbg_pkg::*; ;

  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_idx;
  logic [DW-1:0] out_data;

  modport master (
    output rd_addr, out_valid, out_idx, out_data,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_addr, out_valid, out_idx, out_data,
    output rd_data, out_ready
  );

endinterface

// File: rtl/rf_dump.sv
// Register-file dump engine: walks a latched index range through the debug
// read port and streams {index, data} snapshots over valid/ready.
//
//   state | meaning
//   IDLE  | waiting for start; range latched on accepted start
//   FETCH | rd_addr=ptr; record captured at the next edge
//   SEND  | record held on out_* until the sink takes it
//   DONE  | one-cycle done pulse, then back to IDLE
module rf_dump
  import cpu_dbg_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] first_idx,
  input  logic [AW-1:0] last_idx,
  rf_dump_if.master     dbg,
  output logic          busy,
  output logic          done
);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] last_q, last_d;
  dump_rec_t     rec_q, rec_d;
  logic          valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    rec_d   = rec_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d   = first_idx;
          last_d  = last_idx;
          state_d = (first_idx <= last_idx) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        rec_d.idx  = ptr_q;
        rec_d.data = dbg.rd_data;
        valid_d    = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (dbg.out_ready) begin
          valid_d = 1'b0;
          // Stop on the last index before incrementing, so ptr never wraps.
          if (ptr_q == last_q) begin
            state_d = ST_DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A handshake coinciding with abort still delivered its record;
    // only the pointer advance and the done pulse are suppressed.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      ptr_d   = ptr_q;
      rec_d   = rec_q;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      rec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      rec_q   <= rec_d;
      valid_q <= valid_d;
    end
  end

  assign dbg.rd_addr   = ptr_q;
  assign dbg.out_valid = valid_q;
  assign dbg.out_idx   = rec_q.idx;
  assign dbg.out_data  = rec_q.data;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);

endmodule
